pifo_host_issuer: RTL and testbench
===================================

Name: pifo_host_issuer

Overview:
- Host-side initiator for the multi-tree SRAM PIFO top-level.
- Accepts a single push/pop command stream (valid/ready) and steers each command to the per-level task port that owns the tree (port = tree_id % LEVEL).
- Tracks per-tree occupancy and in-flight pops, then collects the level-0 pop results returned on all levels into one result stream.
- Sits between the traffic manager and the PIFO top; it is the only driver of the top's push/pop ports.

Parameters:
- PTW, 16, payload width
- MTW, 0, metadata width
- CTW, 10, per-tree occupancy counter width
- LEVEL, 4, number of levels / task ports
- TREE_NUM, 4, number of logical trees; TNB = $clog2(TREE_NUM)
- RES_DEPTH, 8, result FIFO depth; also the pop credit limit

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command accepted when valid&ready
- i_cmd_push  in  1  1=push, 0=pop
- i_cmd_tree_id  in  TNB  target tree
- i_cmd_data  in  MTW+PTW  push rank/payload (ignored for pop)
- o_push  out  LEVEL  per-port push pulse to top
- o_pop  out  LEVEL  per-port pop pulse to top
- o_tree_id  out  TNB x LEVEL  per-port tree id
- o_push_data  out  (MTW+PTW) x LEVEL  per-port push data
- i_task_fifo_full  in  LEVEL  per-port task FIFO full
- i_is_level0_pop  in  LEVEL  per-level result strobe
- i_pop_tree_id  in  TNB x LEVEL  result tree id
- i_pop_data  in  (MTW+PTW) x LEVEL  result data
- o_res_valid  out  1  result available
- i_res_ready  in  1  result consumer ready
- o_res_tree_id  out  TNB  result tree id
- o_res_data  out  MTW+PTW  result data
- o_drop  out  1  pulse: command consumed but not issued
- o_unexp_res  out  1  pulse: result strobe with zero in-flight pops

Behaviour:
- Reset:
  - Applies on the i_clk edge with i_rst=1.
  - All outputs, occupancy counters, in-flight counter, hold-off flags and result FIFO clear to 0/empty.
  - Reset mid-operation discards in-flight bookkeeping; later result strobes are flagged via o_unexp_res and dropped.
- Port select: p = i_cmd_tree_id % LEVEL.
- o_cmd_ready is combinational and high iff all of:
  - i_task_fifo_full[p]=0
  - holdoff[p]=0
  - for a pop: inflight + res_count < RES_DEPTH
- Issue:
  - On accept, the o_push[p]/o_pop[p] pulse, o_tree_id[p] and o_push_data[p] are registered and appear exactly 1 cycle later.
  - Pop data is driven as all zeros.
  - Non-selected ports hold push/pop=0 and data=0.
  - At most one port is active per cycle; push and pop are never both driven on one port.
- Hold-off: accepting to port p sets holdoff[p] for the next cycle only. This covers the two-cycle latency before the full flag reflects the new entry, so back-to-back commands to the same port take ≥2 cycles.
- Occupancy, occ[tree] (CTW bits):
  - An issued push increments occ; an issued pop decrements occ and increments inflight.
  - A pop with occ=0 or a push with occ=2^CTW-1 is consumed (ready=1), not issued, and pulses o_drop 1 cycle later.
  - A dropped pop does not take a credit.
- Result collection:
  - Each cycle, every level k with i_is_level0_pop[k]=1 writes {i_pop_tree_id[k], i_pop_data[k]} into the result FIFO.
  - Multiple strobes are written in ascending k order in the same cycle.
  - inflight decrements by the number of strobes written.
  - Strobes beyond inflight are discarded (lowest k kept) and pulse o_unexp_res.
- Credit rule: the credit check guarantees the FIFO never overflows.
- Result FIFO:
  - First-word fall-through; o_res_valid = !empty; head advances on o_res_valid & i_res_ready.
  - A read and up to LEVEL writes in the same cycle are allowed.
  - Pointers wrap modulo RES_DEPTH.
- Widths:
  - inflight and res_count are $clog2(RES_DEPTH+1) bits.
  - Occupancy uses unsigned saturating checks as above; no wrap.

Decomposition:
- pifo_host_pkg holds:
  - typedefs res_entry_t {tree_id, data} and cmd_t {push, tree_id, data}
  - functions port_of(tree_id) and popcount(LEVEL)
- Sub-module pifo_result_mwfifo: LEVEL-write / 1-read FWFT FIFO of res_entry_t, RES_DEPTH entries, with write-compaction logic.

Test Plan:
- Push tree 1 data 0x0010, then push tree 5 data 0x0020 (TREE_NUM=8) -> o_push[1] pulses on consecutive accepts ≥2 cycles apart; occ[1]=1, occ[5]=1.
- i_task_fifo_full[2]=1, command push tree 2 -> o_cmd_ready=0 until full deasserts; a concurrent-cycle command to tree 3 is accepted.
- Pop tree 0 with occ[0]=0 -> ready=1, no o_pop, o_drop pulses once, inflight stays 0.
- Fill: 8 pops issued with i_res_ready=0 -> the 9th pop is held (ready=0); one result popped restores ready on the next cycle.
- Simultaneous i_is_level0_pop=4'b1010 with tree ids 1 and 3, inflight=2 -> FIFO outputs tree 1 then tree 3; inflight=0.
- Assert i_rst with inflight=3, then a strobe on level 0 -> entry dropped, o_unexp_res pulses, o_res_valid stays 0.

Source files
------------

// File: rtl/pifo_host_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pifo_host_pkg : shared types and helpers for the PIFO host issuer  rev 1.0 |
// +--------------------------------------------------------------------------+
package pifo_host_pkg;

   localparam int PTW_DEF       = 16;
   localparam int MTW_DEF       = 0;
   localparam int CTW_DEF       = 10;
   localparam int LEVEL_DEF     = 4;
   localparam int TREE_NUM_DEF  = 4;
   localparam int RES_DEPTH_DEF = 8;
   localparam int TNB_DEF       = $clog2(TREE_NUM_DEF);
   localparam int DW_DEF        = MTW_DEF + PTW_DEF;

   // Views at the default configuration; modules rebuild them from their own parameters.
   typedef struct packed {
      logic [TNB_DEF-1:0] tree_id;
      logic [DW_DEF-1:0]  data;
   } res_entry_t;

   typedef struct packed {
      logic               push;
      logic [TNB_DEF-1:0] tree_id;
      logic [DW_DEF-1:0]  data;
   } cmd_t;

   function automatic int unsigned port_of(input int unsigned tree_id, input int unsigned levels);
      return tree_id % levels;
   endfunction

   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         n = n + int'(v[i]);
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pifo_result_mwfifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pifo_result_mwfifo : LEVEL-write / 1-read FWFT result FIFO        rev 1.0 |
// +--------------------------------------------------------------------------+
module pifo_result_mwfifo
   import pifo_host_pkg::*;
#(
   parameter int  LEVEL   = LEVEL_DEF,
   parameter int  DEPTH   = RES_DEPTH_DEF,
   parameter type entry_t = res_entry_t,
   localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW      = $clog2(DEPTH + 1)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [LEVEL-1:0] wr_en,
   input  entry_t           wr_entry [LEVEL],
   input  logic             rd_en,
   output logic             valid,
   output entry_t           head,
   output logic [CW-1:0]    count
);

   entry_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] slot [LEVEL];
   logic          rd_fire;
   int unsigned   n_wr;

   // Enabled lanes are packed densely from wr_ptr in ascending lane order.
   always_comb begin
      int off;
      off = 0;
      for (int k = 0; k < LEVEL; k++) begin
         slot[k] = AW'((int'(wr_ptr) + off) % DEPTH);
         if (wr_en[k]) begin
            off = off + 1;
         end
      end
   end

   assign n_wr    = popcount(32'(wr_en));
   assign valid   = (count != '0);
   assign rd_fire = rd_en & valid;
   assign head    = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      for (int k = 0; k < LEVEL; k++) begin
         if (wr_en[k]) begin
            mem[slot[k]] <= wr_entry[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= AW'((int'(wr_ptr) + int'(n_wr)) % DEPTH);
         if (rd_fire) begin
            rd_ptr <= AW'((int'(rd_ptr) + 1) % DEPTH);
         end
         count <= count + CW'(n_wr) - CW'(rd_fire);
      end
   end

endmodule
`default_nettype wire

// File: rtl/pifo_host_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pifo_host_issuer : steers push/pop to PIFO task ports, gathers results  rev 1.0 |
// +--------------------------------------------------------------------------+
module pifo_host_issuer
   import pifo_host_pkg::*;
#(
   parameter int  PTW       = PTW_DEF,
   parameter int  MTW       = MTW_DEF,
   parameter int  CTW       = CTW_DEF,
   parameter int  LEVEL     = LEVEL_DEF,
   parameter int  TREE_NUM  = TREE_NUM_DEF,
   parameter int  RES_DEPTH = RES_DEPTH_DEF,
   localparam int TNB       = $clog2(TREE_NUM),
   localparam int DW        = MTW + PTW
)(
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_cmd_valid,
   output logic                           o_cmd_ready,
   input  logic                           i_cmd_push,
   input  logic [TNB-1:0]                 i_cmd_tree_id,
   input  logic [DW-1:0]                  i_cmd_data,
   output logic [LEVEL-1:0]               o_push,
   output logic [LEVEL-1:0]               o_pop,
   output logic [LEVEL-1:0][TNB-1:0]      o_tree_id,
   output logic [LEVEL-1:0][DW-1:0]       o_push_data,
   input  logic [LEVEL-1:0]               i_task_fifo_full,
   input  logic [LEVEL-1:0]               i_is_level0_pop,
   input  logic [LEVEL-1:0][TNB-1:0]      i_pop_tree_id,
   input  logic [LEVEL-1:0][DW-1:0]       i_pop_data,
   output logic                           o_res_valid,
   input  logic                           i_res_ready,
   output logic [TNB-1:0]                 o_res_tree_id,
   output logic [DW-1:0]                  o_res_data,
   output logic                           o_drop,
   output logic                           o_unexp_res
);

   localparam int PW = (LEVEL > 1) ? $clog2(LEVEL) : 1;
   localparam int CW = $clog2(RES_DEPTH + 1);
   localparam logic [CTW-1:0] OCC_MAX = '1;

   typedef struct packed {
      logic [TNB-1:0] tree_id;
      logic [DW-1:0]  data;
   } entry_t;

   logic [CTW-1:0]   occ [TREE_NUM];
   logic [CW-1:0]    inflight;
   logic [CW-1:0]    res_count;
   logic [LEVEL-1:0] holdoff;
   logic [PW-1:0]    sel;
   logic [CTW-1:0]   cur_occ;
   logic             credit_ok;
   logic             accept;
   logic             drop_cmd;
   logic             issue;
   logic [LEVEL-1:0] keep;
   logic [CW-1:0]    n_keep;
   logic             unexp;
   entry_t           wr_entry [LEVEL];
   entry_t           head;

   assign sel       = PW'(port_of(32'(i_cmd_tree_id), LEVEL));
   assign cur_occ   = occ[i_cmd_tree_id];
   assign credit_ok = ({1'b0, inflight} + {1'b0, res_count}) < (CW+1)'(RES_DEPTH);
   assign o_cmd_ready = !i_task_fifo_full[sel] && !holdoff[sel] && (i_cmd_push || credit_ok);
   assign accept    = i_cmd_valid & o_cmd_ready;
   assign drop_cmd  = i_cmd_push ? (cur_occ == OCC_MAX) : (cur_occ == '0);
   assign issue     = accept & !drop_cmd;

   // Keep the lowest-numbered strobes up to the number of pops still owed.
   always_comb begin
      keep   = '0;
      n_keep = '0;
      unexp  = 1'b0;
      for (int k = 0; k < LEVEL; k++) begin
         wr_entry[k] = '{tree_id: i_pop_tree_id[k], data: i_pop_data[k]};
         if (i_is_level0_pop[k]) begin
            if (n_keep < inflight) begin
               keep[k] = 1'b1;
               n_keep  = n_keep + CW'(1);
            end else begin
               unexp = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_push      <= '0;
         o_pop       <= '0;
         o_tree_id   <= '0;
         o_push_data <= '0;
         o_drop      <= 1'b0;
         o_unexp_res <= 1'b0;
         holdoff     <= '0;
         inflight    <= '0;
         for (int t = 0; t < TREE_NUM; t++) begin
            occ[t] <= '0;
         end
      end else begin
         o_push      <= '0;
         o_pop       <= '0;
         o_tree_id   <= '0;
         o_push_data <= '0;
         holdoff     <= '0;
         o_drop      <= accept & drop_cmd;
         o_unexp_res <= unexp;
         // The task FIFO full flag lags an issued entry, so the port sits out one cycle.
         if (accept) begin
            holdoff[sel] <= 1'b1;
         end
         if (issue) begin
            o_tree_id[sel] <= i_cmd_tree_id;
            if (i_cmd_push) begin
               o_push[sel]          <= 1'b1;
               o_push_data[sel]     <= i_cmd_data;
               occ[i_cmd_tree_id]   <= cur_occ + CTW'(1);
            end else begin
               o_pop[sel]           <= 1'b1;
               occ[i_cmd_tree_id]   <= cur_occ - CTW'(1);
            end
         end
         inflight <= inflight - n_keep + CW'(issue & !i_cmd_push);
      end
   end

   pifo_result_mwfifo #(
      .LEVEL   (LEVEL),
      .DEPTH   (RES_DEPTH),
      .entry_t (entry_t)
   ) u_res_fifo (
      .clk      (i_clk),
      .rst      (i_rst),
      .wr_en    (keep),
      .wr_entry (wr_entry),
      .rd_en    (i_res_ready),
      .valid    (o_res_valid),
      .head     (head),
      .count    (res_count)
   );

   assign o_res_tree_id = head.tree_id;
   assign o_res_data    = head.data;

endmodule
`default_nettype wire

// File: tb/tb_pifo_host_issuer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pifo_host_issuer : directed self-checking bench for pifo_host_issuer rev 1.0 |
// +--------------------------------------------------------------------------+
module tb_pifo_host_issuer;

   logic             clk;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_push;
   logic [1:0]       cmd_tree_id;
   logic [15:0]      cmd_data;
   logic [3:0]       push;
   logic [3:0]       pop;
   logic [3:0][1:0]  tree_id;
   logic [3:0][15:0] push_data;
   logic [3:0]       task_fifo_full;
   logic [3:0]       is_level0_pop;
   logic [3:0][1:0]  pop_tree_id;
   logic [3:0][15:0] pop_data;
   logic             res_valid;
   logic             res_ready;
   logic [1:0]       res_tree_id;
   logic [15:0]      res_data;
   logic             drop;
   logic             unexp_res;

   int n_checks;
   int n_errors;

   pifo_host_issuer dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_cmd_valid      (cmd_valid),
      .o_cmd_ready      (cmd_ready),
      .i_cmd_push       (cmd_push),
      .i_cmd_tree_id    (cmd_tree_id),
      .i_cmd_data       (cmd_data),
      .o_push           (push),
      .o_pop            (pop),
      .o_tree_id        (tree_id),
      .o_push_data      (push_data),
      .i_task_fifo_full (task_fifo_full),
      .i_is_level0_pop  (is_level0_pop),
      .i_pop_tree_id    (pop_tree_id),
      .i_pop_data       (pop_data),
      .o_res_valid      (res_valid),
      .i_res_ready      (res_ready),
      .o_res_tree_id    (res_tree_id),
      .o_res_data       (res_data),
      .o_drop           (drop),
      .o_unexp_res      (unexp_res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one command, wait (bounded) for ready, then check issue vs drop.
   task automatic do_cmd(input logic is_push, input int tid, input logic [15:0] data,
                         input logic exp_issue);
      int waited;
      int p;
      logic [3:0] exp_vec;
      waited      = 0;
      cmd_valid   = 1'b1;
      cmd_push    = is_push;
      cmd_tree_id = tid[1:0];
      cmd_data    = data;
      #1;
      while (!cmd_ready && waited < 20) begin
         step();
         waited = waited + 1;
      end
      check("cmd_wait", 32'(waited < 20), 32'(1));
      step();
      cmd_valid = 1'b0;
      p       = tid % 4;
      exp_vec = exp_issue ? 4'(1 << p) : 4'b0000;
      if (is_push) begin
         check("push_pulse", 32'(push), 32'(exp_vec));
      end else begin
         check("pop_pulse", 32'(pop), 32'(exp_vec));
      end
      check("drop_pulse", 32'(drop), 32'(!exp_issue));
      step();
   endtask

   initial begin
      logic [1:0]  exp_tid [5];
      logic [15:0] exp_dat [5];
      n_checks       = 0;
      n_errors       = 0;
      rst            = 1'b1;
      cmd_valid      = 1'b0;
      cmd_push       = 1'b0;
      cmd_tree_id    = '0;
      cmd_data       = '0;
      task_fifo_full = '0;
      is_level0_pop  = '0;
      pop_tree_id    = '0;
      pop_data       = '0;
      res_ready      = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();

      check("rst_res_valid", 32'(res_valid), 32'(0));
      check("rst_push", 32'(push), 32'(0));
      check("rst_pop", 32'(pop), 32'(0));
      check("rst_drop", 32'(drop), 32'(0));
      check("rst_ready", 32'(cmd_ready), 32'(1));

      // Back-to-back pushes to the same port are spaced by the hold-off cycle.
      cmd_valid = 1'b1; cmd_push = 1'b1; cmd_tree_id = 2'd1; cmd_data = 16'h0010;
      #1 check("push1_ready", 32'(cmd_ready), 32'(1));
      step();
      check("push1_pulse", 32'(push), 32'(4'b0010));
      check("push1_tid", 32'(tree_id[1]), 32'(1));
      check("push1_data", 32'(push_data[1]), 32'(16'h0010));
      cmd_data = 16'h0020;
      #1 check("holdoff_ready", 32'(cmd_ready), 32'(0));
      step();
      check("holdoff_no_issue", 32'(push), 32'(0));
      check("holdoff_cleared", 32'(cmd_ready), 32'(1));
      step();
      check("push2_pulse", 32'(push), 32'(4'b0010));
      check("push2_data", 32'(push_data[1]), 32'(16'h0020));
      cmd_valid = 1'b0;
      step();

      // Full on port 2 blocks it while port 3 is still accepted.
      task_fifo_full = 4'b0100;
      cmd_valid = 1'b1; cmd_push = 1'b1; cmd_tree_id = 2'd2; cmd_data = 16'h0022;
      #1 check("full_blocks", 32'(cmd_ready), 32'(0));
      cmd_tree_id = 2'd3; cmd_data = 16'h0033;
      #1 check("other_port_ready", 32'(cmd_ready), 32'(1));
      step();
      check("push3_pulse", 32'(push), 32'(4'b1000));
      check("push3_data", 32'(push_data[3]), 32'(16'h0033));
      cmd_tree_id = 2'd2; cmd_data = 16'h0022;
      #1 check("full_still_blocks", 32'(cmd_ready), 32'(0));
      step();
      check("full_no_issue", 32'(push), 32'(0));
      task_fifo_full = 4'b0000;
      #1 check("full_released", 32'(cmd_ready), 32'(1));
      step();
      check("push2p_pulse", 32'(push), 32'(4'b0100));
      check("push2p_data", 32'(push_data[2]), 32'(16'h0022));
      cmd_valid = 1'b0;
      step();

      // Pop of an empty tree is consumed and dropped.
      do_cmd(1'b0, 0, 16'h0, 1'b0);
      check("drop_one_cycle", 32'(drop), 32'(0));

      // occ: t0=0,t1=2,t2=1,t3=1 -> bring t0 to 4, then issue 8 pops.
      for (int i = 0; i < 4; i++) do_cmd(1'b1, 0, 16'(16'h0A00 + i), 1'b1);
      for (int i = 0; i < 4; i++) do_cmd(1'b0, 0, 16'h0, 1'b1);
      do_cmd(1'b0, 1, 16'h0, 1'b1);
      do_cmd(1'b0, 1, 16'h0, 1'b1);
      do_cmd(1'b0, 2, 16'h0, 1'b1);
      do_cmd(1'b0, 3, 16'h0, 1'b1);
      cmd_push = 1'b0; cmd_tree_id = 2'd3;
      #1 check("credit_exhausted", 32'(cmd_ready), 32'(0));
      cmd_push = 1'b1;
      #1 check("push_ignores_credit", 32'(cmd_ready), 32'(1));
      cmd_push = 1'b0;

      pop_tree_id[0] = 2'd0; pop_data[0] = 16'hAAAA; is_level0_pop = 4'b0001;
      step();
      is_level0_pop = 4'b0000;
      check("res1_valid", 32'(res_valid), 32'(1));
      check("res1_tid", 32'(res_tree_id), 32'(0));
      check("res1_data", 32'(res_data), 32'(16'hAAAA));
      check("res1_unexp", 32'(unexp_res), 32'(0));
      check("credit_held_by_fifo", 32'(cmd_ready), 32'(0));
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check("credit_restored", 32'(cmd_ready), 32'(1));
      check("res1_drained", 32'(res_valid), 32'(0));

      // Two simultaneous strobes (inflight=7) come out in ascending level order.
      pop_tree_id[1] = 2'd1; pop_data[1] = 16'h1111;
      pop_tree_id[3] = 2'd3; pop_data[3] = 16'h3333;
      is_level0_pop = 4'b1010;
      step();
      is_level0_pop = 4'b0000;
      check("multi_first_tid", 32'(res_tree_id), 32'(1));
      check("multi_first_data", 32'(res_data), 32'(16'h1111));
      check("multi_unexp", 32'(unexp_res), 32'(0));
      res_ready = 1'b1;
      step();
      check("multi_second_tid", 32'(res_tree_id), 32'(3));
      check("multi_second_data", 32'(res_data), 32'(16'h3333));
      step();
      res_ready = 1'b0;
      check("multi_drained", 32'(res_valid), 32'(0));

      // inflight=5: four strobes leave 1; then two strobes keep only level 1.
      for (int k = 0; k < 4; k++) begin
         pop_tree_id[k] = 2'(k);
         pop_data[k]    = 16'(16'hB000 + k);
      end
      is_level0_pop = 4'b1111;
      step();
      check("four_unexp", 32'(unexp_res), 32'(0));
      is_level0_pop = 4'b0110;
      step();
      is_level0_pop = 4'b0000;
      check("excess_unexp", 32'(unexp_res), 32'(1));
      exp_tid[0] = 2'd0; exp_dat[0] = 16'hB000;
      exp_tid[1] = 2'd1; exp_dat[1] = 16'hB001;
      exp_tid[2] = 2'd2; exp_dat[2] = 16'hB002;
      exp_tid[3] = 2'd3; exp_dat[3] = 16'hB003;
      exp_tid[4] = 2'd1; exp_dat[4] = 16'hB001;
      check("excess_unexp_clear", 32'(unexp_res), 32'(1));
      res_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("drain_valid", 32'(res_valid), 32'(1));
         check("drain_tid", 32'(res_tree_id), 32'(exp_tid[i]));
         check("drain_data", 32'(res_data), 32'(exp_dat[i]));
         step();
      end
      res_ready = 1'b0;
      check("drain_empty", 32'(res_valid), 32'(0));
      check("unexp_back_low", 32'(unexp_res), 32'(0));

      // Reset with three pops outstanding discards the bookkeeping.
      for (int i = 0; i < 3; i++) do_cmd(1'b1, 1, 16'h0111, 1'b1);
      for (int i = 0; i < 3; i++) do_cmd(1'b0, 1, 16'h0, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_res_valid", 32'(res_valid), 32'(0));
      check("midrst_pop", 32'(pop), 32'(0));
      pop_tree_id[0] = 2'd1; pop_data[0] = 16'hC0DE; is_level0_pop = 4'b0001;
      step();
      is_level0_pop = 4'b0000;
      check("post_rst_unexp", 32'(unexp_res), 32'(1));
      check("post_rst_no_res", 32'(res_valid), 32'(0));
      do_cmd(1'b0, 1, 16'h0, 1'b0);

      // Occupancy saturates at 2^CTW-1: the next push is dropped.
      for (int i = 0; i < 1023; i++) do_cmd(1'b1, 2, 16'(i), 1'b1);
      do_cmd(1'b1, 2, 16'hFFFF, 1'b0);
      do_cmd(1'b0, 2, 16'h0, 1'b1);
      do_cmd(1'b1, 2, 16'h1234, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
